gray_downsample_2x2: RTL

GRAY_DOWNSAMPLE_2X2 -- requirements
Module: gray_downsample_2x2

---
 rtl/gray_downsample_2x2.sv | 128 ++++++++++++
 1 files changed

// File: rtl/gray_downsample_2x2.sv
// Gray-scale 2x2 box downsampler.
// Averages each non-overlapping 2x2 block of a raster-order gray frame into
// one output pixel (sum >> 2, truncated). Horizontal pairs are summed on the
// fly; even-row pair sums wait in a half-width line buffer until the matching
// odd-row pair arrives.
//
// Handshake: a beat transfers on any rising edge where valid and ready are
// both high. On the input side that is valid_i & ready_o; on the output side
// valid_o & ready_i. The output register is a single stage, so ready_o is
// high whenever the register is empty or is being drained this cycle. While
// valid_o is high and ready_i is low, gray_o/last_o/valid_o stay frozen.
module gray_downsample_2x2 #(
    parameter int width_p        = 8,
    parameter int frame_width_p  = 640,
    parameter int frame_height_p = 480
) (
    input  logic               clk_i,
    input  logic               reset_i,
    input  logic               valid_i,
    input  logic [width_p-1:0] gray_i,
    output logic               ready_o,
    output logic               valid_o,
    output logic [width_p-1:0] gray_o,
    output logic               last_o,
    input  logic               ready_i
);

    localparam int col_w_lp     = (frame_width_p  > 2) ? $clog2(frame_width_p)  : 1;
    localparam int row_w_lp     = (frame_height_p > 2) ? $clog2(frame_height_p) : 1;
    localparam int buf_depth_lp = frame_width_p / 2;
    localparam int idx_w_lp     = (buf_depth_lp > 1) ? $clog2(buf_depth_lp) : 1;

    // Position counters and the even-column pixel holding register
    logic [col_w_lp-1:0] col_q, col_d;
    logic [row_w_lp-1:0] row_q, row_d;
    logic [width_p-1:0]  pair_q, pair_d;

    // Output register
    logic                valid_q, valid_d;
    logic [width_p-1:0]  gray_q, gray_d;
    logic                last_q, last_d;

    // Line buffer of even-row pair sums; never reset, always written before read
    logic [width_p:0]    line_buf_q [buf_depth_lp];

    logic                accept;
    logic                col_last;
    logic                row_last;
    logic                produce;
    logic                buf_we;
    logic [idx_w_lp-1:0] buf_idx;
    logic [width_p:0]    pair_sum;
    logic [width_p+1:0]  quad_sum;

    assign ready_o = ready_i | ~valid_q;
    assign valid_o = valid_q;
    assign gray_o  = gray_q;
    assign last_o  = last_q;

    // Datapath sums, position tracking and pair holding
    always_comb begin
        accept   = valid_i & ready_o;
        col_last = (col_q == col_w_lp'(frame_width_p - 1));
        row_last = (row_q == row_w_lp'(frame_height_p - 1));
        buf_idx  = idx_w_lp'(col_q >> 1);
        pair_sum = {1'b0, pair_q} + {1'b0, gray_i};
        quad_sum = {1'b0, pair_sum} + {1'b0, line_buf_q[buf_idx]};
        produce  = accept & col_q[0] & row_q[0];
        buf_we   = accept & col_q[0] & ~row_q[0];

        col_d  = col_q;
        row_d  = row_q;
        pair_d = pair_q;
        if (accept) begin
            if (!col_q[0]) begin
                pair_d = gray_i;
            end
            if (col_last) begin
                col_d = '0;
                row_d = row_last ? '0 : row_q + row_w_lp'(1);
            end else begin
                col_d = col_q + col_w_lp'(1);
            end
        end
    end

    // Output register: load on a completing beat, clear on drain, else hold
    always_comb begin
        valid_d = valid_q;
        gray_d  = gray_q;
        last_d  = last_q;
        if (produce) begin
            valid_d = 1'b1;
            gray_d  = width_p'(quad_sum >> 2);
            last_d  = row_last & col_last;
        end else if (ready_i) begin
            valid_d = 1'b0;
            last_d  = 1'b0;
        end
    end

    // State registers with synchronous reset
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            col_q   <= '0;
            row_q   <= '0;
            pair_q  <= '0;
            valid_q <= 1'b0;
            gray_q  <= '0;
            last_q  <= 1'b0;
        end else begin
            col_q   <= col_d;
            row_q   <= row_d;
            pair_q  <= pair_d;
            valid_q <= valid_d;
            gray_q  <= gray_d;
            last_q  <= last_d;
        end
    end

    // Line buffer write of even-row pair sums
    always_ff @(posedge clk_i) begin
        if (buf_we) begin
            line_buf_q[buf_idx] <= pair_sum;
        end
    end

endmodule
